// File: rtl/wt_dcache_ship_trainer_if.sv
// Access request and SHiP predictor signals between the dcache controller and the trainer.
// master = cache pipeline / SHCT side, slave = trainer.
interface wt_dcache_ship_trainer_if #(
    parameter int NumSets  = 256,
    parameter int SigWidth = 14
);
    localparam int SetW = $clog2(NumSets);

    logic                          acc_valid_i;
    logic                          acc_ready_o;
    logic [SetW-1:0]               acc_set_i;
    logic                          acc_hit_i;
    logic [3:0]                    acc_hit_way_i;
    logic [3:0]                    acc_way_vld_i;
    logic [63:0]                   acc_pc_i;
    logic                          victim_valid_o;
    logic [3:0]                    victim_way_o;
    logic                          pred_hit_o;
    logic [SigWidth-1:0]           pred_hit_shct_o;
    logic                          pred_miss_o;
    logic [3:0]                    pred_outcome_o;
    logic [3:0][SigWidth-1:0]      pred_miss_shct_o;
    logic [3:0]                    pred_miss_way_o;
    logic [SigWidth-1:0]           pred_shct_o;
    logic [1:0]                    pred_result_i;

    modport master (
        output acc_valid_i, acc_set_i, acc_hit_i, acc_hit_way_i, acc_way_vld_i, acc_pc_i,
               pred_result_i,
        input  acc_ready_o, victim_valid_o, victim_way_o, pred_hit_o, pred_hit_shct_o,
               pred_miss_o, pred_outcome_o, pred_miss_shct_o, pred_miss_way_o, pred_shct_o
    );

    modport slave (
        input  acc_valid_i, acc_set_i, acc_hit_i, acc_hit_way_i, acc_way_vld_i, acc_pc_i,
               pred_result_i,
        output acc_ready_o, victim_valid_o, victim_way_o, pred_hit_o, pred_hit_shct_o,
               pred_miss_o, pred_outcome_o, pred_miss_shct_o, pred_miss_way_o, pred_shct_o
    );
endinterface

// File: rtl/wt_dcache_ship_trainer.sv
// SHiP metadata keeper and SHCT training initiator: SRRIP victim selection with aging.
// Hits: 1/cycle, pulse next cycle. Misses: ready drops for 1-7 cycles while SCAN/AGE resolve a victim.
module wt_dcache_ship_trainer #(
    parameter int NumSets  = 256,
    parameter int NumWays  = 4,
    parameter int SigWidth = 14
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    wt_dcache_ship_trainer_if.slave bus
);
    localparam int SetW = $clog2(NumSets);

    typedef struct packed {
        logic [SigWidth-1:0] sig;
        logic                out;
        logic [1:0]          rrpv;
    } meta_t;

    typedef enum logic [1:0] {IDLE, SCAN, AGE} state_e;

    state_e              state_q, state_d;
    meta_t               meta_q [NumSets][NumWays];
    meta_t               meta_d [NumSets][NumWays];
    logic [SetW-1:0]     set_q, set_d;
    logic [SigWidth-1:0] sig_q, sig_d;
    logic [NumWays-1:0]  vld_q, vld_d;
    logic                hit_pulse_q, hit_pulse_d;
    logic [SigWidth-1:0] hit_sig_q, hit_sig_d;

    logic                kill;
    logic                accept;
    logic [SigWidth-1:0] acc_sig;
    logic                victim_found;
    logic [NumWays-1:0]  victim_oh;
    logic                scan_fire;
    logic [NumWays-1:0]  outcome;
    logic [3:0][SigWidth-1:0] shcts;
    logic                unused_pc;

    assign kill      = rst_i | flush_i;
    assign accept    = bus.acc_valid_i && (state_q == IDLE);
    assign acc_sig   = bus.acc_pc_i[15:2] ^ bus.acc_pc_i[29:16];
    assign unused_pc = ^{bus.acc_pc_i[63:30], bus.acc_pc_i[1:0]};

    // Invalid ways take priority; only a full set falls back to the rrpv==3 search.
    always_comb begin
        victim_found = 1'b0;
        victim_oh    = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (!victim_found &&
                ((vld_q != '1 && !vld_q[w]) ||
                 (vld_q == '1 && meta_q[set_q][w].rrpv == 2'd3))) begin
                victim_oh[w] = 1'b1;
                victim_found = 1'b1;
            end
        end
    end

    assign scan_fire = (state_q == SCAN) && victim_found && !kill;

    always_comb begin
        outcome = '0;
        shcts   = '0;
        if (scan_fire) begin
            for (int w = 0; w < NumWays; w++) begin
                outcome[w] = meta_q[set_q][w].out;
                shcts[w]   = meta_q[set_q][w].sig;
            end
        end
    end

    assign bus.acc_ready_o      = (state_q == IDLE);
    assign bus.victim_valid_o   = scan_fire;
    assign bus.victim_way_o     = scan_fire ? victim_oh : '0;
    assign bus.pred_miss_o      = scan_fire && |(victim_oh & vld_q);
    assign bus.pred_miss_way_o  = scan_fire ? victim_oh : '0;
    assign bus.pred_outcome_o   = outcome;
    assign bus.pred_miss_shct_o = shcts;
    assign bus.pred_shct_o      = (state_q != IDLE && !kill) ? sig_q : '0;
    assign bus.pred_hit_o       = hit_pulse_q && !kill;
    assign bus.pred_hit_shct_o  = (hit_pulse_q && !kill) ? hit_sig_q : '0;

    always_comb begin
        state_d     = state_q;
        meta_d      = meta_q;
        set_d       = set_q;
        sig_d       = sig_q;
        vld_d       = vld_q;
        hit_pulse_d = 1'b0;
        hit_sig_d   = hit_sig_q;

        if (kill) begin
            state_d = IDLE;
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    meta_d[s][w] = '{sig: '0, out: 1'b0, rrpv: 2'd3};
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && bus.acc_hit_i) begin
                        hit_pulse_d = 1'b1;
                        for (int w = 0; w < NumWays; w++) begin
                            if (bus.acc_hit_way_i[w]) begin
                                hit_sig_d                           = meta_q[bus.acc_set_i][w].sig;
                                meta_d[bus.acc_set_i][w].rrpv = 2'd0;
                                meta_d[bus.acc_set_i][w].out  = 1'b1;
                            end
                        end
                    end else if (accept) begin
                        set_d   = bus.acc_set_i;
                        sig_d   = acc_sig;
                        vld_d   = bus.acc_way_vld_i;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (victim_found) begin
                        // A zero SHCT counter predicts distant reuse: insert at the eviction point.
                        for (int w = 0; w < NumWays; w++) begin
                            if (victim_oh[w]) begin
                                meta_d[set_q][w] = '{sig:  sig_q,
                                                     out:  1'b0,
                                                     rrpv: (bus.pred_result_i == 2'd0) ? 2'd3 : 2'd2};
                            end
                        end
                        state_d = IDLE;
                    end else begin
                        state_d = AGE;
                    end
                end
                AGE: begin
                    for (int w = 0; w < NumWays; w++) begin
                        if (meta_q[set_q][w].rrpv != 2'd3) begin
                            meta_d[set_q][w].rrpv = meta_q[set_q][w].rrpv + 2'd1;
                        end
                    end
                    state_d = SCAN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            set_q       <= '0;
            sig_q       <= '0;
            vld_q       <= '0;
            hit_pulse_q <= 1'b0;
            hit_sig_q   <= '0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            sig_q       <= sig_d;
            vld_q       <= vld_d;
            hit_pulse_q <= hit_pulse_d;
            hit_sig_q   <= hit_sig_d;
        end
        meta_q <= meta_d;
    end

    hit_way_onehot_a: assert property (@(posedge clk_i) disable iff (kill)
        (accept && bus.acc_hit_i) |-> $onehot(bus.acc_hit_way_i));

endmodule

// File: tb/tb_wt_dcache_ship_trainer.sv
module tb_wt_dcache_ship_trainer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    wt_dcache_ship_trainer_if #(.NumSets(256), .SigWidth(14)) bus ();

    wt_dcache_ship_trainer #(.NumSets(256), .NumWays(4), .SigWidth(14)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    typedef struct packed {
        logic [3:0]       way;
        logic             miss;
        logic [3:0]       outc;
        logic [3:0][13:0] shcts;
        logic [13:0]      sig;
        logic [3:0]       lat;
    } exp_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [13:0] msig [256][4];
    logic        mout [256][4];
    logic [1:0]  mrr  [256][4];
    exp_t        mq[$];
    logic [13:0] hq[$];

    function automatic logic [13:0] f_sig(input logic [63:0] pc);
        logic [63:0] p;
        p = pc;
        return p[15:2] ^ p[29:16];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 256; s++)
            for (int w = 0; w < 4; w++) begin
                msig[s][w] = '0; mout[s][w] = 1'b0; mrr[s][w] = 2'd3;
            end
    endtask

    task automatic idle_inputs();
        bus.acc_valid_i = 1'b0; bus.acc_set_i = '0; bus.acc_hit_i = 1'b0;
        bus.acc_hit_way_i = '0; bus.acc_way_vld_i = '0; bus.acc_pc_i = '0;
        bus.pred_result_i = '0;
    endtask

    task automatic do_miss(input int s, input logic [3:0] vld, input logic [63:0] pc,
                           input logic [1:0] pr, output int lat, output logic [3:0] way,
                           output logic miss);
        exp_t e, g;
        int ages, vidx;
        logic found;
        bit got;
        e = '0; ages = 0; found = 1'b0; vidx = 0; got = 0;
        lat = 0; way = '0; miss = 1'b0;
        while (!found && ages < 8) begin
            for (int w = 0; w < 4; w++)
                if (!found && (vld == 4'hF ? (mrr[s][w] == 2'd3) : !vld[w])) begin
                    e.way[w] = 1'b1; found = 1'b1; vidx = w;
                end
            if (!found) begin
                ages++;
                for (int w = 0; w < 4; w++) if (mrr[s][w] != 2'd3) mrr[s][w] = mrr[s][w] + 2'd1;
            end
        end
        for (int w = 0; w < 4; w++) begin
            e.outc[w] = mout[s][w]; e.shcts[w] = msig[s][w];
        end
        e.miss = vld[vidx];
        e.sig  = f_sig(pc);
        e.lat  = 4'(2 * ages + 1);
        msig[s][vidx] = f_sig(pc); mout[s][vidx] = 1'b0;
        mrr[s][vidx]  = (pr == 2'd0) ? 2'd3 : 2'd2;
        mq.push_back(e);

        bus.acc_valid_i = 1'b1; bus.acc_hit_i = 1'b0; bus.acc_set_i = 8'(s);
        bus.acc_way_vld_i = vld; bus.acc_pc_i = pc; bus.pred_result_i = pr;
        @(posedge clk); #1;
        bus.acc_valid_i = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (bus.victim_valid_o) begin
                got = 1; lat = c; way = bus.victim_way_o; miss = bus.pred_miss_o;
                g = mq.pop_front();
                n_chk++; if (bus.victim_way_o !== g.way) $display("FAIL victim_way set %0d: got %b want %b", s, bus.victim_way_o, g.way); else n_pass++;
                n_chk++; if (bus.pred_miss_o !== g.miss) $display("FAIL pred_miss set %0d: got %b want %b", s, bus.pred_miss_o, g.miss); else n_pass++;
                n_chk++; if (bus.pred_miss_way_o !== g.way) $display("FAIL pred_miss_way set %0d: got %b want %b", s, bus.pred_miss_way_o, g.way); else n_pass++;
                n_chk++; if (bus.pred_outcome_o !== g.outc) $display("FAIL pred_outcome set %0d: got %b want %b", s, bus.pred_outcome_o, g.outc); else n_pass++;
                n_chk++; if (bus.pred_miss_shct_o !== g.shcts) $display("FAIL pred_miss_shct set %0d: got %h want %h", s, bus.pred_miss_shct_o, g.shcts); else n_pass++;
                n_chk++; if (bus.pred_shct_o !== g.sig) $display("FAIL pred_shct set %0d: got %h want %h", s, bus.pred_shct_o, g.sig); else n_pass++;
                n_chk++; if (c !== int'(g.lat)) $display("FAIL miss_latency set %0d: got %0d want %0d", s, c, g.lat); else n_pass++;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL victim_timeout set %0d: no victim_valid_o within 12 cycles", s);
            void'(mq.pop_front());
        end
        n_chk++; if (bus.acc_ready_o !== 1'b1) $display("FAIL ready_after_miss: got %b want 1", bus.acc_ready_o); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.victim_valid_o !== 1'b0) $display("FAIL victim_pulse_width: got %b want 0", bus.victim_valid_o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic do_hit(input int s, input int w, output logic [13:0] shct);
        logic [13:0] exp_sig;
        hq.push_back(msig[s][w]);
        mrr[s][w] = 2'd0; mout[s][w] = 1'b1;
        bus.acc_valid_i = 1'b1; bus.acc_hit_i = 1'b1; bus.acc_set_i = 8'(s);
        bus.acc_hit_way_i = 4'(1 << w); bus.acc_way_vld_i = 4'hF;
        @(posedge clk); #1;
        bus.acc_valid_i = 1'b0; bus.acc_hit_i = 1'b0;
        @(negedge clk);
        exp_sig = hq.pop_front();
        shct = bus.pred_hit_shct_o;
        n_chk++; if (bus.pred_hit_o !== 1'b1) $display("FAIL pred_hit set %0d way %0d: got %b want 1", s, w, bus.pred_hit_o); else n_pass++;
        n_chk++; if (bus.pred_hit_shct_o !== exp_sig) $display("FAIL pred_hit_shct set %0d way %0d: got %h want %h", s, w, bus.pred_hit_shct_o, exp_sig); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic fill_set(input int s, input logic [1:0] pr_last);
        int lat; logic [3:0] way; logic miss;
        do_miss(s, 4'b0000, 64'h1000 + 64'(s * 64), 2'd2, lat, way, miss);
        do_miss(s, 4'b0001, 64'h2000 + 64'(s * 64), 2'd2, lat, way, miss);
        do_miss(s, 4'b0011, 64'h3000 + 64'(s * 64), 2'd2, lat, way, miss);
        do_miss(s, 4'b0111, 64'h4000 + 64'(s * 64), pr_last, lat, way, miss);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if ({bus.victim_valid_o, bus.pred_hit_o, bus.pred_miss_o} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {bus.victim_valid_o, bus.pred_hit_o, bus.pred_miss_o}); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_chk++; if (bus.acc_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.acc_ready_o); else n_pass++;
        n_chk++; if (dut.meta_q[0][0] !== 17'd3) $display("FAIL reset_meta_0_0: got %h want 00003", dut.meta_q[0][0]); else n_pass++;
        n_chk++; if (dut.meta_q[255][3] !== 17'd3) $display("FAIL reset_meta_255_3: got %h want 00003", dut.meta_q[255][3]); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_first_fill();
        int lat; logic [3:0] way; logic miss; logic [13:0] sh;
        do_miss(5, 4'b0000, 64'h0000_0000_0012_3450, 2'd2, lat, way, miss);
        n_chk++; if (way !== 4'b0001) $display("FAIL t1_victim_way: got %b want 0001", way); else n_pass++;
        n_chk++; if (miss !== 1'b0) $display("FAIL t1_pred_miss: got %b want 0", miss); else n_pass++;
        n_chk++; if (lat !== 1) $display("FAIL t1_latency: got %0d want 1", lat); else n_pass++;
        n_chk++; if ({dut.meta_q[5][0].out, dut.meta_q[5][0].rrpv} !== 3'b010) $display("FAIL t1_way0_meta: got %b want 010", {dut.meta_q[5][0].out, dut.meta_q[5][0].rrpv}); else n_pass++;
        // Build set 5 up to rrpv {0,1,2,1}, outcomes {1,1,0,1}.
        do_miss(5, 4'b0001, 64'h2220, 2'd2, lat, way, miss);
        do_miss(5, 4'b0011, 64'h3330, 2'd2, lat, way, miss);
        do_miss(5, 4'b0111, 64'h4440, 2'd2, lat, way, miss);
        do_hit(5, 0, sh); do_hit(5, 1, sh); do_hit(5, 3, sh);
        do_miss(5, 4'b1111, 64'h5550, 2'd2, lat, way, miss);
        do_hit(5, 0, sh);
    endtask

    task automatic test_age_once();
        int lat; logic [3:0] way; logic miss;
        do_miss(5, 4'b1111, 64'h6660, 2'd1, lat, way, miss);
        n_chk++; if (way !== 4'b0100) $display("FAIL t2_victim_way: got %b want 0100", way); else n_pass++;
        n_chk++; if (lat !== 3) $display("FAIL t2_latency: got %0d want 3", lat); else n_pass++;
        n_chk++; if (miss !== 1'b1) $display("FAIL t2_pred_miss: got %b want 1", miss); else n_pass++;
        n_chk++; if (dut.meta_q[5][1].rrpv !== 2'd2) $display("FAIL t2_way1_aged: got %0d want 2", dut.meta_q[5][1].rrpv); else n_pass++;
    endtask

    task automatic test_hit_sig();
        int lat; logic [3:0] way; logic miss; logic [13:0] sh;
        do_miss(7, 4'b0001, 64'h0000_6AF0, 2'd1, lat, way, miss);
        do_hit(7, 1, sh);
        n_chk++; if (sh !== 14'h1ABC) $display("FAIL t3_hit_shct: got %h want 1abc", sh); else n_pass++;
        n_chk++; if ({dut.meta_q[7][1].out, dut.meta_q[7][1].rrpv} !== 3'b100) $display("FAIL t3_way1_meta: got %b want 100", {dut.meta_q[7][1].out, dut.meta_q[7][1].rrpv}); else n_pass++;
    endtask

    task automatic test_distant_insert();
        int lat; logic [3:0] way; logic miss;
        fill_set(11, 2'd0);
        n_chk++; if (dut.meta_q[11][3].rrpv !== 2'd3) $display("FAIL t4_insert_rrpv: got %0d want 3", dut.meta_q[11][3].rrpv); else n_pass++;
        do_miss(11, 4'b1111, 64'h7770, 2'd2, lat, way, miss);
        n_chk++; if (way !== 4'b1000) $display("FAIL t4_victim_way: got %b want 1000", way); else n_pass++;
        n_chk++; if (lat !== 1) $display("FAIL t4_latency: got %0d want 1", lat); else n_pass++;
    endtask

    task automatic test_age_three();
        int lat; logic [3:0] way; logic miss; logic [13:0] sh;
        fill_set(20, 2'd2);
        for (int w = 0; w < 4; w++) do_hit(20, w, sh);
        do_miss(20, 4'b1111, 64'h8880, 2'd3, lat, way, miss);
        n_chk++; if (way !== 4'b0001) $display("FAIL t5_victim_way: got %b want 0001", way); else n_pass++;
        n_chk++; if (lat !== 7) $display("FAIL t5_latency: got %0d want 7", lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [13:0] e0, e1;
        e0 = msig[5][0]; e1 = msig[5][2];
        mrr[5][0] = 2'd0; mout[5][0] = 1'b1; mrr[5][2] = 2'd0; mout[5][2] = 1'b1;
        bus.acc_valid_i = 1'b1; bus.acc_hit_i = 1'b1; bus.acc_set_i = 8'd5; bus.acc_hit_way_i = 4'b0001;
        @(posedge clk); #1;
        bus.acc_hit_way_i = 4'b0100;
        @(negedge clk);
        n_chk++; if ({bus.pred_hit_o, bus.pred_hit_shct_o} !== {1'b1, e0}) $display("FAIL b2b_first: got %b/%h want 1/%h", bus.pred_hit_o, bus.pred_hit_shct_o, e0); else n_pass++;
        n_chk++; if (bus.acc_ready_o !== 1'b1) $display("FAIL b2b_ready: got %b want 1", bus.acc_ready_o); else n_pass++;
        @(posedge clk); #1;
        bus.acc_valid_i = 1'b0; bus.acc_hit_i = 1'b0;
        @(negedge clk);
        n_chk++; if ({bus.pred_hit_o, bus.pred_hit_shct_o} !== {1'b1, e1}) $display("FAIL b2b_second: got %b/%h want 1/%h", bus.pred_hit_o, bus.pred_hit_shct_o, e1); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; logic [3:0] way; logic miss; logic [13:0] sh;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_hit(40 + $urandom_range(3, 0), $urandom_range(3, 0), sh);
            else
                do_miss(40 + $urandom_range(3, 0), 4'($urandom_range(15, 0)),
                        {$urandom, $urandom}, 2'($urandom_range(3, 0)), lat, way, miss);
        end
    endtask

    task automatic test_flush_age();
        int lat; logic [3:0] way; logic miss; logic [13:0] sh;
        fill_set(9, 2'd2);
        for (int w = 0; w < 4; w++) do_hit(9, w, sh);
        bus.acc_valid_i = 1'b1; bus.acc_hit_i = 1'b0; bus.acc_set_i = 8'd9;
        bus.acc_way_vld_i = 4'hF; bus.acc_pc_i = 64'h9990; bus.pred_result_i = 2'd2;
        @(posedge clk); #1;
        bus.acc_valid_i = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.victim_valid_o !== 1'b0) $display("FAIL t6_scan_no_victim: got %b want 0", bus.victim_valid_o); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus.victim_valid_o, bus.pred_miss_o, bus.pred_hit_o} !== 3'b000) $display("FAIL t6_flush_pulses: got %b want 000", {bus.victim_valid_o, bus.pred_miss_o, bus.pred_hit_o}); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0;
        model_reset();
        @(negedge clk);
        n_chk++; if ({bus.acc_ready_o, bus.victim_valid_o} !== 2'b10) $display("FAIL t6_idle_after_flush: got %b want 10", {bus.acc_ready_o, bus.victim_valid_o}); else n_pass++;
        for (int w = 0; w < 4; w++) begin
            n_chk++; if (dut.meta_q[9][w] !== 17'd3) $display("FAIL t6_meta_reset way %0d: got %h want 00003", w, dut.meta_q[9][w]); else n_pass++;
        end
        @(posedge clk); #1;
        do_miss(9, 4'b1111, 64'hAAA0, 2'd2, lat, way, miss);
        n_chk++; if (way !== 4'b0001) $display("FAIL t6_victim_way: got %b want 0001", way); else n_pass++;
        n_chk++; if (lat !== 1) $display("FAIL t6_latency: got %0d want 1", lat); else n_pass++;
    endtask

    task automatic test_flush_hit();
        bus.acc_valid_i = 1'b1; bus.acc_hit_i = 1'b1; bus.acc_set_i = 8'd9; bus.acc_hit_way_i = 4'b0001;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.acc_valid_i = 1'b0; bus.acc_hit_i = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.pred_hit_o !== 1'b0) $display("FAIL flush_same_cycle_hit: got %b want 0", bus.pred_hit_o); else n_pass++;
        n_chk++; if (dut.meta_q[9][0] !== 17'd3) $display("FAIL flush_hit_meta: got %h want 00003", dut.meta_q[9][0]); else n_pass++;
        @(posedge clk); #1;
        bus.acc_valid_i = 1'b1; bus.acc_hit_i = 1'b1; bus.acc_hit_way_i = 4'b0010;
        @(posedge clk); #1;
        bus.acc_valid_i = 1'b0; bus.acc_hit_i = 1'b0; flush = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.pred_hit_o !== 1'b0) $display("FAIL flush_pending_hit: got %b want 0", bus.pred_hit_o); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_age_once();
        test_hit_sig();
        test_distant_insert();
        test_age_three();
        test_back_to_back();
        test_random();
        test_flush_age();
        test_flush_hit();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
